// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: sequences single register-transfer commands into one-hot
// bus-drive / load strobes for a bank of 1-bit REG instances, with a settle
// cycle between driving the bus and loading the destination.
module reg_xfer_ctrl #(
  parameter int unsigned NREG = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [IDXW-1:0] cmd_src,
  input  logic [IDXW-1:0] cmd_dst,
  output logic [NREG-1:0] out_use,
  output logic [NREG-1:0] in_use,
  output logic            const_en,
  output logic            const_val,
  output logic            busy,
  output logic            cmd_done,
  output logic            cmd_err
);

  // Index compare width carries one extra bit so NREG == 2**IDXW is representable.
  localparam int unsigned CW = IDXW + 1;
  localparam logic [CW-1:0] NREG_W = CW'(NREG);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [1:0]      op_q, op_d;
  logic [IDXW-1:0] src_q, src_d;
  logic [IDXW-1:0] dst_q, dst_d;
  logic            err_q, err_d;

  logic            illegal;
  logic [NREG-1:0] out_use_d;
  logic [NREG-1:0] in_use_d;
  logic            const_en_d;
  logic            const_val_d;
  logic            cmd_ready_d;
  logic            busy_d;
  logic            cmd_done_d;
  logic            cmd_err_d;

  // One-hot decode of a register index; out-of-range indices decode to zero.
  function automatic logic [NREG-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      v[i] = (CW'(idx) == CW'(i));
    end
    return v;
  endfunction

  // Command legality: destination (and MOV source) must address an existing REG.
  always_comb begin
    illegal = 1'b0;
    if (CW'(cmd_dst) >= NREG_W) begin
      illegal = 1'b1;
    end
    if ((cmd_op == OP_MOV) && (CW'(cmd_src) >= NREG_W)) begin
      illegal = 1'b1;
    end
  end

  // Next-state logic, command latch, and next values of all registered outputs.
  always_comb begin
    state_d     = state;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    err_d       = err_q;
    out_use_d   = '0;
    in_use_d    = '0;
    const_en_d  = 1'b0;
    const_val_d = 1'b0;
    cmd_done_d  = 1'b0;
    cmd_err_d   = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          src_d = cmd_src;
          dst_d = cmd_dst;
          err_d = illegal;
          if (illegal || (cmd_op == OP_NOP) ||
              ((cmd_op == OP_MOV) && (cmd_src == cmd_dst))) begin
            state_d = DONE;
          end else begin
            state_d = DRIVE;
          end
        end
      end
      DRIVE:   state_d = LOAD;
      LOAD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus source is held through DRIVE and LOAD; only legal commands reach these states.
    if ((state_d == DRIVE) || (state_d == LOAD)) begin
      if (op_d == OP_MOV) begin
        out_use_d = onehot(src_d);
      end else begin
        const_en_d  = 1'b1;
        const_val_d = op_d[0];
      end
    end

    if (state_d == LOAD) begin
      in_use_d = onehot(dst_d);
    end

    if (state_d == DONE) begin
      cmd_done_d = 1'b1;
      cmd_err_d  = err_d;
    end

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State, latched command and output registers; reset discards any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      src_q     <= '0;
      dst_q     <= '0;
      err_q     <= 1'b0;
      out_use   <= '0;
      in_use    <= '0;
      const_en  <= 1'b0;
      const_val <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      err_q     <= err_d;
      out_use   <= out_use_d;
      in_use    <= in_use_d;
      const_en  <= const_en_d;
      const_val <= const_val_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      cmd_done  <= cmd_done_d;
      cmd_err   <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: directed command sequence with a retirement
// scoreboard and per-cycle bus-driver / load invariant checks on two instances
// (NREG=4 and NREG=3).
module tb_reg_xfer_ctrl;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] MOV = 2'b01;
  localparam logic [1:0] CLR = 2'b10;
  localparam logic [1:0] SET = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_valid3;
  logic [1:0] cmd_op, cmd_src, cmd_dst;

  logic       cmd_ready, const_en, const_val, busy, cmd_done, cmd_err;
  logic [3:0] out_use, in_use;
  logic       cmd_ready3, const_en3, const_val3, busy3, cmd_done3, cmd_err3;
  logic [2:0] out_use3, in_use3;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic err;
    int   cyc;
  } exp_t;
  exp_t q4[$];
  exp_t q3[$];

  reg_xfer_ctrl #(.NREG(4), .IDXW(2)) u_dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .out_use(out_use), .in_use(in_use), .const_en(const_en), .const_val(const_val),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  reg_xfer_ctrl #(.NREG(3), .IDXW(2)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .out_use(out_use3), .in_use(in_use3), .const_en(const_en3), .const_val(const_val3),
    .busy(busy3), .cmd_done(cmd_done3), .cmd_err(cmd_err3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp4(input string tag, input logic [3:0] eo, input logic [3:0] ei,
                      input logic ec, input logic ev, input logic ed, input logic er);
    chk({tag, "_out_use"}, out_use, eo);
    chk({tag, "_in_use"}, in_use, ei);
    chk({tag, "_const_en"}, const_en, ec);
    chk({tag, "_const_val"}, const_val, ev);
    chk({tag, "_done"}, cmd_done, ed);
    chk({tag, "_err"}, cmd_err, er);
  endtask

  task automatic exp3(input string tag, input logic [2:0] eo, input logic [2:0] ei,
                      input logic ec, input logic ev, input logic ed, input logic er);
    chk({tag, "_out_use"}, out_use3, eo);
    chk({tag, "_in_use"}, in_use3, ei);
    chk({tag, "_const_en"}, const_en3, ec);
    chk({tag, "_const_val"}, const_val3, ev);
    chk({tag, "_done"}, cmd_done3, ed);
    chk({tag, "_err"}, cmd_err3, er);
  endtask

  // Called at a negedge: present a command and record when it should retire.
  task automatic send4(input string tag, input logic [1:0] op, input logic [1:0] src,
                       input logic [1:0] dst, input logic err, input int lat);
    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    q4.push_back('{err, cyc + lat});
  endtask

  task automatic send3(input string tag, input logic [1:0] op, input logic [1:0] src,
                       input logic [1:0] dst, input logic err, input int lat);
    chk({tag, "_ready"}, cmd_ready3, 1);
    cmd_valid3 = 1'b1;
    cmd_op     = op;
    cmd_src    = src;
    cmd_dst    = dst;
    q3.push_back('{err, cyc + lat});
  endtask

  // Per-cycle invariants and scoreboard retirement for the NREG=4 instance.
  always @(negedge clk) begin
    if (!reset) begin
      chk("inv_one_driver4", ($countones(out_use) + 32'(const_en)) <= 1, 1);
      chk("inv_one_load4", $countones(in_use) <= 1, 1);
      chk("inv_load_has_src4", (in_use == 4'd0) || (out_use != 4'd0) || const_en, 1);
      chk("inv_busy4", busy, !cmd_ready);
      chk("inv_err_wo_done4", cmd_err && !cmd_done, 0);
      if (cmd_done) begin
        if (q4.size() == 0) begin
          chk("done_unexpected4", 1, 0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          chk("done_cycle4", cyc, e.cyc);
          chk("done_err4", cmd_err, e.err);
        end
      end
    end
  end

  // Same checks for the NREG=3 instance.
  always @(negedge clk) begin
    if (!reset) begin
      chk("inv_one_driver3", ($countones(out_use3) + 32'(const_en3)) <= 1, 1);
      chk("inv_one_load3", $countones(in_use3) <= 1, 1);
      chk("inv_load_has_src3", (in_use3 == 3'd0) || (out_use3 != 3'd0) || const_en3, 1);
      chk("inv_busy3", busy3, !cmd_ready3);
      chk("inv_err_wo_done3", cmd_err3 && !cmd_done3, 0);
      if (cmd_done3) begin
        if (q3.size() == 0) begin
          chk("done_unexpected3", 1, 0);
        end else begin
          exp_t e;
          e = q3.pop_front();
          chk("done_cycle3", cyc, e.cyc);
          chk("done_err3", cmd_err3, e.err);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_valid3 = 1'b0;
    cmd_op     = NOP;
    cmd_src    = 2'd0;
    cmd_dst    = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    exp4("rst", 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("rst_busy", busy, 0);
    exp3("rst3", 3'b000, 3'b000, 0, 0, 0, 0);
    reset = 1'b0;

    // Reset release: idle and ready until the first command
    repeat (3) begin
      @(negedge clk);
      exp4("idle", 4'b0000, 4'b0000, 0, 0, 0, 0);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
    end

    // MOV src=1 dst=3
    send4("mov13", MOV, 2'd1, 2'd3, 0, 3);
    @(negedge clk); cmd_valid = 1'b0;
    exp4("mov13_c1", 4'b0010, 4'b0000, 0, 0, 0, 0);
    chk("mov13_c1_busy", busy, 1);
    @(negedge clk); exp4("mov13_c2", 4'b0010, 4'b1000, 0, 0, 0, 0);
    @(negedge clk); exp4("mov13_c3", 4'b0000, 4'b0000, 0, 0, 1, 0);
    @(negedge clk); exp4("mov13_c4", 4'b0000, 4'b0000, 0, 0, 0, 0);

    // SET dst=2 then CLR dst=2 with valid held; inputs change while busy
    send4("set2", SET, 2'd0, 2'd2, 0, 3);
    @(negedge clk); cmd_op = CLR;
    exp4("set2_c1", 4'b0000, 4'b0000, 1, 1, 0, 0);
    chk("set2_c1_ready", cmd_ready, 0);
    @(negedge clk); exp4("set2_c2", 4'b0000, 4'b0100, 1, 1, 0, 0);
    @(negedge clk); exp4("set2_c3", 4'b0000, 4'b0000, 0, 0, 1, 0);
    @(negedge clk); exp4("set2_c4", 4'b0000, 4'b0000, 0, 0, 0, 0);
    send4("clr2", CLR, 2'd0, 2'd2, 0, 3);
    @(negedge clk); cmd_valid = 1'b0;
    exp4("clr2_c5", 4'b0000, 4'b0000, 1, 0, 0, 0);
    @(negedge clk); exp4("clr2_c6", 4'b0000, 4'b0100, 1, 0, 0, 0);
    @(negedge clk); exp4("clr2_c7", 4'b0000, 4'b0000, 0, 0, 1, 0);
    @(negedge clk); exp4("clr2_c8", 4'b0000, 4'b0000, 0, 0, 0, 0);

    // NOP and self-MOV retire in one cycle without strobes
    send4("nop", NOP, 2'd2, 2'd1, 0, 1);
    @(negedge clk); cmd_valid = 1'b0;
    exp4("nop_c1", 4'b0000, 4'b0000, 0, 0, 1, 0);
    @(negedge clk); exp4("nop_c2", 4'b0000, 4'b0000, 0, 0, 0, 0);
    send4("mov00", MOV, 2'd0, 2'd0, 0, 1);
    @(negedge clk); cmd_valid = 1'b0;
    exp4("mov00_c1", 4'b0000, 4'b0000, 0, 0, 1, 0);
    @(negedge clk); exp4("mov00_c2", 4'b0000, 4'b0000, 0, 0, 0, 0);

    // NREG=3 instance: illegal source, illegal destination, then a legal MOV
    send3("ill_src", MOV, 2'd3, 2'd0, 1, 1);
    @(negedge clk); cmd_valid3 = 1'b0;
    exp3("ill_src_c1", 3'b000, 3'b000, 0, 0, 1, 1);
    @(negedge clk); exp3("ill_src_c2", 3'b000, 3'b000, 0, 0, 0, 0);
    send3("ill_dst", SET, 2'd0, 2'd3, 1, 1);
    @(negedge clk); cmd_valid3 = 1'b0;
    exp3("ill_dst_c1", 3'b000, 3'b000, 0, 0, 1, 1);
    @(negedge clk); exp3("ill_dst_c2", 3'b000, 3'b000, 0, 0, 0, 0);
    send3("mov20", MOV, 2'd2, 2'd0, 0, 3);
    @(negedge clk); cmd_valid3 = 1'b0;
    exp3("mov20_c1", 3'b100, 3'b000, 0, 0, 0, 0);
    @(negedge clk); exp3("mov20_c2", 3'b100, 3'b001, 0, 0, 0, 0);
    @(negedge clk); exp3("mov20_c3", 3'b000, 3'b000, 0, 0, 1, 0);
    @(negedge clk); exp3("mov20_c4", 3'b000, 3'b000, 0, 0, 0, 0);

    // Reset during LOAD of MOV 0->1 discards the command
    send4("mov01", MOV, 2'd0, 2'd1, 0, 3);
    @(negedge clk); cmd_valid = 1'b0;
    exp4("mov01_c1", 4'b0001, 4'b0000, 0, 0, 0, 0);
    @(negedge clk); exp4("mov01_c2", 4'b0001, 4'b0010, 0, 0, 0, 0);
    #2 reset = 1'b1;
    q4.delete();
    #1 exp4("mov01_rst", 4'b0000, 4'b0000, 0, 0, 0, 0);
    chk("mov01_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      exp4("post_rst", 4'b0000, 4'b0000, 0, 0, 0, 0);
      chk("post_rst_ready", cmd_ready, 1);
    end

    chk("sb_empty", q4.size() + q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
